pin_pulser: RTL



---
 rtl/pin_pulser_pkg.sv | 13 +
 rtl/cycle_timer.sv | 19 +
 rtl/pin_pulser.sv | 95 +++++++++
 3 files changed

// File: rtl/pin_pulser_pkg.sv
// pin_pulser_pkg: shared FSM type, widths and default phase lengths (SYSCLOCK_FREQ defaults to 50 MHz if unset)
`ifndef SYSCLOCK_FREQ
`define SYSCLOCK_FREQ 50_000_000
`endif
package pin_pulser_pkg;
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
   localparam int COUNT_W = 8;
   localparam int DEF_ON_CYCLES = `SYSCLOCK_FREQ / 50;
   localparam int DEF_OFF_CYCLES = `SYSCLOCK_FREQ / 50;
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter whose expired flag marks the last cycle of a loaded period
module cycle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);
   logic [W-1:0] cnt_q, cnt_d;
   // reload on request, otherwise count down to zero and hold there
   always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   // counter register
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign expired = cnt_q == W'(1);
endmodule

// File: rtl/pin_pulser.sv
// pin_pulser: emits COUNT debounce-safe pulses on PIN per START; PIN_PULSER_ABORT_EN adds an ABORT input
module pin_pulser
   import pin_pulser_pkg::*;
#(
   parameter logic C_ACTIVE   = 1'b1,
   parameter int   ON_CYCLES  = DEF_ON_CYCLES,
   parameter int   OFF_CYCLES = DEF_OFF_CYCLES
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               START,
`ifdef PIN_PULSER_ABORT_EN
   input  logic               ABORT,
`endif
   input  logic [COUNT_W-1:0] COUNT,
   output logic               PIN,
   output logic               BUSY,
   output logic               DONE
);
   localparam int TW = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
   state_t state_q, state_d;
   logic [COUNT_W-1:0] rem_q, rem_d;
   logic pin_q, pin_d, busy_q, busy_d, done_q, done_d;
   logic tmr_load, tmr_exp, abort;
   logic [TW-1:0] tmr_val;
`ifdef PIN_PULSER_ABORT_EN
   assign abort = ABORT;
`else
   assign abort = 1'b0;
`endif
   cycle_timer #(.W(TW)) u_timer (
      .clk      (CLK),
      .rst      (RESET),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );
   // next state, phase timer reloads and remaining-pulse bookkeeping
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      tmr_load = 1'b0;
      tmr_val  = TW'(ON_CYCLES);
      done_d   = 1'b0;
      case (state_q)
         IDLE: if (START && COUNT != '0) begin
            state_d  = ON;
            rem_d    = COUNT;
            tmr_load = 1'b1;
         end
         ON: if (tmr_exp || abort) begin
            state_d  = OFF;
            tmr_load = 1'b1;
            tmr_val  = TW'(OFF_CYCLES);
            rem_d    = abort ? '0 : rem_q - 1'b1;
         end
         OFF: begin
            if (abort) rem_d = '0;
            if (tmr_exp) begin
               if (abort || rem_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ON;
                  tmr_load = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // outputs are derived from the next state so they come straight off flops
   always_comb begin
      pin_d  = (state_d == ON) ? C_ACTIVE : ~C_ACTIVE;
      busy_d = state_d != IDLE;
   end
   // state, counter and output registers
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         state_q <= IDLE;
         rem_q   <= '0;
         pin_q   <= ~C_ACTIVE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         pin_q   <= pin_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   assign PIN  = pin_q;
   assign BUSY = busy_q;
   assign DONE = done_q;
endmodule
